i2c_sht_target: RTL and testbench

Synchronous I2C target (peripheral) that answers the SHT40 transaction our I2C master issues. Used as the bus-side counterpart of the master, both in simulation and as an on-FPGA sensor stand-in.
- Write cycle: ACKs its 7-bit address, captures the one-byte command, and flags it to the fabric.
- Read cycle: returns six bytes, i.e. two 16-bit words, each followed by its Sensirion CRC-8.
- SDA is open-drain style: 0 drives low, 1 releases.

---
 rtl/i2c_pkg.sv | 44 ++++
 rtl/i2c_sht_target_if.sv | 9 +
 rtl/sht_crc8.sv | 9 +
 rtl/i2c_sht_target.sv | 199 +++++++++++++++++++
 tb/tb_i2c_sht_target.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM encodings, SHT40 constants and the Sensirion CRC-8 helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_CMD       = 3'd3,
    ST_CMD_ACK   = 3'd4,
    ST_TX        = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  // SCL phase encodings used by the companion master
  typedef enum logic [1:0] {
    SCL_HIGH = 2'd0,
    SCL_FALL = 2'd1,
    SCL_LOW  = 2'd2,
    SCL_RISE = 2'd3
  } scl_phase_t;

  localparam logic [7:0] CRC_POLY       = 8'h31;
  localparam logic [7:0] CRC_INIT       = 8'hFF;
  localparam logic [7:0] CMD_MEASURE_HP = 8'hFD;
  localparam logic [7:0] CMD_SOFT_RESET = 8'h94;

  // Bit-serial CRC-8 over a 16-bit word, MSB first
  function automatic logic [7:0] crc8_16(input logic [15:0] data);
    logic [7:0] c;
    logic       fb;
    c = CRC_INIT;
    for (int i = 15; i >= 0; i--) begin
      fb = c[7] ^ data[i];
      if (fb) begin
        c = {c[6:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/i2c_sht_target_if.sv
// I2C pin bundle between a bus master and the SHT target; sda_out is open-drain (0 pulls low).
interface i2c_sht_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_out;

  modport master (output scl_in, output sda_in, input sda_out);
  modport slave  (input scl_in, input sda_in, output sda_out);
endinterface

// File: rtl/sht_crc8.sv
// Combinational Sensirion CRC-8 of one 16-bit measurement word.
module sht_crc8
  import i2c_pkg::*;
(
  input  logic [15:0] i_data,
  output logic [7:0]  o_crc
);
  assign o_crc = crc8_16(i_data);
endmodule

// File: rtl/i2c_sht_target.sv
// I2C target emulating an SHT40: accepts command writes, returns temp/hum words with CRCs on reads.
module i2c_sht_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h44,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_sht_target_if.slave      bus,
  input  logic [15:0]          temp_word,
  input  logic [15:0]          hum_word,
  output logic [7:0]           cmd_byte,
  output logic                 cmd_valid,
  output logic                 busy,
  output logic [2:0]           state_out
);

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_d, r_sda_d;
  logic r_ev_start, r_ev_stop, r_ev_rise, r_ev_fall, r_sda_smp;
  logic w_scl, w_sda;

  state_t         r_state;
  logic [3:0]     r_bit_cnt;
  logic [2:0]     r_byte_cnt;
  logic [7:0]     r_shift;
  logic           r_rw;
  logic           r_ack_drv;
  logic [5:0][7:0] r_buf;
  logic           r_sda_out;
  logic [7:0]     r_cmd_byte;
  logic           r_cmd_valid;
  logic           r_busy;
  logic [7:0]     w_crc_temp, w_crc_hum, w_tx_byte;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  sht_crc8 u_crc_temp (.i_data(temp_word), .o_crc(w_crc_temp));
  sht_crc8 u_crc_hum  (.i_data(hum_word),  .o_crc(w_crc_hum));

  // Past the six measurement bytes the target keeps returning 0xFF
  assign w_tx_byte = (r_byte_cnt < 3'd6) ? r_buf[r_byte_cnt] : 8'hFF;

  // Synchronizers, edge-detect register and registered bus events
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= {SYNC_STAGES{1'b1}};
      r_sda_sync <= {SYNC_STAGES{1'b1}};
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_ev_start <= 1'b0;
      r_ev_stop  <= 1'b0;
      r_ev_rise  <= 1'b0;
      r_ev_fall  <= 1'b0;
      r_sda_smp  <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_ev_start <= r_scl_d & w_scl & r_sda_d & ~w_sda;
      r_ev_stop  <= r_scl_d & w_scl & ~r_sda_d & w_sda;
      r_ev_rise  <= ~r_scl_d & w_scl;
      r_ev_fall  <= r_scl_d & ~w_scl;
      r_sda_smp  <= w_sda;
    end
  end

  // Protocol FSM; START/STOP preempt any bit-level activity
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 4'd0;
      r_byte_cnt  <= 3'd0;
      r_shift     <= 8'd0;
      r_rw        <= 1'b0;
      r_ack_drv   <= 1'b0;
      r_buf       <= 48'd0;
      r_sda_out   <= 1'b1;
      r_cmd_byte  <= 8'd0;
      r_cmd_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      if (r_ev_stop) begin
        r_state    <= ST_IDLE;
        r_sda_out  <= 1'b1;
        r_busy     <= 1'b0;
        r_bit_cnt  <= 4'd0;
        r_byte_cnt <= 3'd0;
        r_ack_drv  <= 1'b0;
      end else if (r_ev_start) begin
        r_state    <= ST_ADDR;
        r_sda_out  <= 1'b1;
        r_bit_cnt  <= 4'd0;
        r_byte_cnt <= 3'd0;
        r_ack_drv  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_sda_out <= 1'b1;
          end
          ST_ADDR: begin
            if (r_ev_rise) begin
              r_shift <= {r_shift[6:0], r_sda_smp};
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= 4'd0;
                if (r_shift[6:0] == TARGET_ADDR) begin
                  r_state <= ST_ADDR_ACK;
                  r_busy  <= 1'b1;
                  r_rw    <= r_sda_smp;
                  if (r_sda_smp) begin
                    r_buf <= {w_crc_hum, hum_word[7:0], hum_word[15:8],
                              w_crc_temp, temp_word[7:0], temp_word[15:8]};
                  end
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ST_ADDR_ACK, ST_CMD_ACK: begin
            // First falling edge starts the ACK, the second ends it
            if (r_ev_fall) begin
              if (!r_ack_drv) begin
                r_sda_out <= 1'b0;
                r_ack_drv <= 1'b1;
              end else begin
                r_ack_drv <= 1'b0;
                if (r_state == ST_ADDR_ACK && r_rw) begin
                  r_state   <= ST_TX;
                  r_sda_out <= w_tx_byte[7];
                  r_bit_cnt <= 4'd1;
                end else begin
                  r_state   <= ST_CMD;
                  r_sda_out <= 1'b1;
                end
              end
            end
          end
          ST_CMD: begin
            if (r_ev_rise) begin
              r_shift <= {r_shift[6:0], r_sda_smp};
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt   <= 4'd0;
                r_cmd_byte  <= {r_shift[6:0], r_sda_smp};
                r_cmd_valid <= 1'b1;
                r_state     <= ST_CMD_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ST_TX: begin
            if (r_ev_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_out <= 1'b1;
                r_bit_cnt <= 4'd0;
                r_state   <= ST_TX_ACK;
              end else begin
                r_sda_out <= w_tx_byte[3'd7 - r_bit_cnt[2:0]];
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ST_TX_ACK: begin
            if (r_ev_rise) begin
              if (!r_sda_smp) begin
                r_byte_cnt <= (r_byte_cnt == 3'd6) ? 3'd6 : r_byte_cnt + 3'd1;
                r_bit_cnt  <= 4'd0;
                r_state    <= ST_TX;
              end else begin
                r_state <= ST_WAIT_STOP;
              end
            end
          end
          ST_WAIT_STOP: begin
            r_sda_out <= 1'b1;
          end
          default: begin
            r_state   <= ST_IDLE;
            r_sda_out <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.sda_out = r_sda_out;
  assign cmd_byte    = r_cmd_byte;
  assign cmd_valid   = r_cmd_valid;
  assign busy        = r_busy;
  assign state_out   = r_state;

endmodule

// File: tb/tb_i2c_sht_target.sv
// Directed bench for i2c_sht_target: bit-banged master on a wired-AND SDA with hand-computed bytes.
module tb_i2c_sht_target;
  import i2c_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [15:0] temp_word = 16'hBEEF;
  logic [15:0] hum_word  = 16'h1234;
  logic [7:0]  cmd_byte;
  logic        cmd_valid, busy;
  logic [2:0]  state_out;

  i2c_sht_target_if bus ();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & bus.sda_out;

  i2c_sht_target #(.TARGET_ADDR(7'h44), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .temp_word(temp_word), .hum_word(hum_word),
    .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .busy(busy), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int   n_vec = 0, n_miss = 0;
  int   valid_cnt = 0, valid_wide = 0;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    if (cmd_valid) valid_cnt++;
    if (cmd_valid && valid_prev) valid_wide++;
    valid_prev = cmd_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; tick(5);
    m_scl = 1'b1; tick(5);
    m_sda = 1'b0; tick(5);
    m_scl = 1'b0; tick(5);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; tick(5);
    m_scl = 1'b1; tick(5);
    m_sda = 1'b1; tick(10);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    tick(5);
    m_scl = 1'b1; tick(10);
    m_scl = 1'b0; tick(5);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; tick(5);
    m_scl = 1'b1; tick(5);
    b = bus.sda_in;
    tick(5);
    m_scl = 1'b0; tick(5);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_sda);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack_sda);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bt);
      d[i] = bt;
    end
    send_bit(nack);
  endtask

  logic [7:0] rd1 [6] = '{8'hBE, 8'hEF, 8'h92, 8'h12, 8'h34, 8'h37};
  logic [7:0] rd2 [5] = '{8'hBE, 8'hEF, 8'h92, 8'h56, 8'h78};

  initial begin
    logic       a;
    logic [7:0] d;
    int         t;
    tick(3);
    check("rst_sda_out",   32'(bus.sda_out), 32'd1);
    check("rst_cmd_byte",  32'(cmd_byte),    32'd0);
    check("rst_cmd_valid", 32'(cmd_valid),   32'd0);
    check("rst_busy",      32'(busy),        32'd0);
    check("rst_state",     32'(state_out),   32'(ST_IDLE));
    rst = 1'b0;
    tick(5);

    // Write 0x88 + 0xFD
    i2c_start;
    write_byte(8'h88, a);
    check("wr_addr_ack", 32'(a), 32'd0);
    check("wr_busy", 32'(busy), 32'd1);
    write_byte(CMD_MEASURE_HP, a);
    check("wr_cmd_ack", 32'(a), 32'd0);
    check("wr_cmd_byte", 32'(cmd_byte), 32'hFD);
    i2c_stop;
    check("wr_valid_cnt", 32'(valid_cnt), 32'd1);
    check("wr_busy_stop", 32'(busy), 32'd0);
    check("wr_state_stop", 32'(state_out), 32'(ST_IDLE));

    // Read six bytes; temp changes mid-read must not affect the snapshot
    i2c_start;
    write_byte(8'h89, a);
    check("rd_addr_ack", 32'(a), 32'd0);
    for (int k = 0; k < 6; k++) begin
      read_byte(k == 5, d);
      if (k == 0) temp_word = 16'h0000;
      check($sformatf("rd_byte%0d", k), 32'(d), 32'(rd1[k]));
    end
    check("rd_state_nack", 32'(state_out), 32'(ST_WAIT_STOP));
    check("rd_sda_release", 32'(bus.sda_out), 32'd1);
    i2c_stop;
    temp_word = 16'hBEEF;
    check("rd_state_stop", 32'(state_out), 32'(ST_IDLE));

    // Non-matching address 0x48
    i2c_start;
    write_byte(8'h90, a);
    check("na_no_ack", 32'(a), 32'd1);
    check("na_busy", 32'(busy), 32'd0);
    check("na_state", 32'(state_out), 32'(ST_WAIT_STOP));
    check("na_valid_cnt", 32'(valid_cnt), 32'd1);
    i2c_stop;
    check("na_state_stop", 32'(state_out), 32'(ST_IDLE));

    // Repeated START after two bytes, with a new humidity word
    i2c_start;
    write_byte(8'h89, a);
    read_byte(1'b0, d);
    check("rs_first0", 32'(d), 32'hBE);
    read_byte(1'b0, d);
    check("rs_first1", 32'(d), 32'hEF);
    hum_word = 16'h5678;
    i2c_start;
    check("rs_state_addr", 32'(state_out), 32'(ST_ADDR));
    write_byte(8'h89, a);
    check("rs_addr_ack", 32'(a), 32'd0);
    for (int k = 0; k < 5; k++) begin
      read_byte(k == 4, d);
      check($sformatf("rs_byte%0d", k), 32'(d), 32'(rd2[k]));
    end
    i2c_stop;
    hum_word = 16'h1234;

    // STOP after four command bits
    i2c_start;
    write_byte(8'h88, a);
    check("pc_addr_ack", 32'(a), 32'd0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop;
    check("pc_state", 32'(state_out), 32'(ST_IDLE));
    check("pc_cmd_byte", 32'(cmd_byte), 32'hFD);
    check("pc_valid_cnt", 32'(valid_cnt), 32'd1);

    // Reset pulse while the address ACK is driven
    i2c_start;
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 3);
    t = 0;
    while (bus.sda_out !== 1'b0 && t < 20) begin
      tick(1);
      t++;
    end
    check("rs_ack_driven", 32'(bus.sda_out), 32'd0);
    check("rs_ack_state", 32'(state_out), 32'(ST_ADDR_ACK));
    rst = 1'b1;
    tick(1);
    check("rst_mid_sda", 32'(bus.sda_out), 32'd1);
    check("rst_mid_state", 32'(state_out), 32'(ST_IDLE));
    rst = 1'b0;
    recv_bit(a);
    write_byte(CMD_SOFT_RESET, a);
    check("rst_ignored_ack", 32'(a), 32'd1);
    check("rst_ignored_state", 32'(state_out), 32'(ST_IDLE));
    check("rst_ignored_busy", 32'(busy), 32'd0);
    check("rst_ignored_valid", 32'(valid_cnt), 32'd1);
    i2c_start;
    write_byte(8'h88, a);
    check("post_addr_ack", 32'(a), 32'd0);
    write_byte(CMD_SOFT_RESET, a);
    check("post_cmd_ack", 32'(a), 32'd0);
    i2c_stop;
    check("post_cmd_byte", 32'(cmd_byte), 32'h94);
    check("post_valid_cnt", 32'(valid_cnt), 32'd2);
    check("valid_width", 32'(valid_wide), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
